// File: rtl/sample_playback_ctrl.sv
// -----------------------------------------------------------------------------
// sample_playback_ctrl
//
// Plays back 8-bit samples packed four to a 32-bit word from the DDR3-to-DAC
// FIFO. A trigger edge starts a playback of play_len words. Each word is split
// into bytes [7:0], [15:8], [23:16], [31:24] and emitted at one sample per rate
// tick. The tick period is max(rate_div,1)+1 okClk cycles.
//
// Optional feature macro: PLAYBACK_SIGNED_EN
//   undefined : bytes are unsigned, ampl = {4'b0, byte}, reset ampl = 12'h000
//   defined   : bytes are two's complement, ampl = {~byte[7], byte[6:0], 4'b0},
//               reset ampl = 12'h800 (mid-scale)
//
// Ports
//   okClk        in   sole clock, rising edge
//   mst_reset_n  in   synchronous active-low reset
//   trigger      in   asynchronous start request (synchronised internally)
//   play_len     in   words to play, latched at start
//   rate_div     in   okClk cycles per sample minus 1, latched at start
//   fifo_dout    in   FIFO word, valid the cycle after fifo_rd_en
//   fifo_empty   in   FIFO empty flag
//   fifo_rd_en   out  FIFO read strobe
//   ampl         out  12-bit amplitude to the DAC controller
//   sample_valid out  one-cycle pulse whenever ampl updates
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse at the end of a playback
//   underrun     out  sticky: FIFO ran dry after playback had started emitting
// -----------------------------------------------------------------------------
module sample_playback_ctrl #(
    parameter int RATE_W = 16,
    parameter int LEN_W  = 24
) (
    input  logic              okClk,
    input  logic              mst_reset_n,
    input  logic              trigger,
    input  logic [LEN_W-1:0]  play_len,
    input  logic [RATE_W-1:0] rate_div,
    input  logic [31:0]       fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [11:0]       ampl,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, FINISH} state_t;

`ifdef PLAYBACK_SIGNED_EN
    localparam logic [11:0] AMPL_RST = 12'h800;
`else
    localparam logic [11:0] AMPL_RST = 12'h000;
`endif

    // Byte-to-DAC mapping. The signed form flips the sign bit to convert
    // two's complement into offset binary, then scales to 12 bits.
`ifdef PLAYBACK_SIGNED_EN
    function automatic logic [11:0] to_ampl(input logic signed [7:0] smp);
        return {~smp[7], smp[6:0], 4'b0000};
    endfunction
`else
    function automatic logic [11:0] to_ampl(input logic [7:0] smp);
        return {4'b0000, smp};
    endfunction
`endif

    state_t            state;
    logic              trig_s1, trig_s2, trig_d;
    logic              start;
    logic [LEN_W-1:0]  len_rem;
    logic [RATE_W-1:0] div_eff;
    logic [RATE_W-1:0] tick_cnt;
    logic              tick;
    logic [31:0]       word_q;
    logic [1:0]        byte_idx;    // byte currently shown on ampl
    logic [1:0]        byte_nxt;
    logic              pend0;       // word loaded but its byte 0 waits for a tick
    logic              emitted;     // at least one sample out this playback

    assign start    = trig_s2 & ~trig_d;
    assign tick     = (tick_cnt == div_eff);
    assign byte_nxt = byte_idx + 2'd1;
    assign busy     = (state != IDLE);

    // Combinational strobe so it can never be high on an empty FIFO; also held
    // low during reset so an aborted playback issues no read.
    assign fifo_rd_en = mst_reset_n && (state == FETCH) && !fifo_empty;

    // Word holding register: pure data, loaded the cycle the FIFO presents it.
    always_ff @(posedge okClk) begin
        if (state == LOAD) begin
            word_q <= fifo_dout;
        end
    end

    always_ff @(posedge okClk) begin
        if (!mst_reset_n) begin
            state        <= IDLE;
            trig_s1      <= 1'b0;
            trig_s2      <= 1'b0;
            trig_d       <= 1'b0;
            len_rem      <= '0;
            div_eff      <= '0;
            tick_cnt     <= '0;
            byte_idx     <= 2'd0;
            pend0        <= 1'b0;
            emitted      <= 1'b0;
            ampl         <= AMPL_RST;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            trig_s1      <= trigger;
            trig_s2      <= trig_s1;
            trig_d       <= trig_s2;
            sample_valid <= 1'b0;
            done         <= 1'b0;

            // The rate counter keeps running through FETCH/LOAD so word
            // boundaries stay on the same sample grid as bytes within a word.
            if (state == IDLE) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + RATE_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start && (play_len != '0)) begin
                        len_rem  <= play_len;
                        div_eff  <= (rate_div == '0) ? RATE_W'(1) : rate_div;
                        underrun <= 1'b0;
                        emitted  <= 1'b0;
                        pend0    <= 1'b0;
                        byte_idx <= 2'd0;
                        state    <= FETCH;
                    end
                end

                FETCH: begin
                    if (!fifo_empty) begin
                        state <= LOAD;
                    end else if (emitted) begin
                        underrun <= 1'b1;
                    end
                end

                LOAD: begin
                    state    <= PLAY;
                    byte_idx <= 2'd0;
                    // First word of a playback starts at once; later words
                    // start on the tick so spacing stays uniform.
                    if (!emitted || tick) begin
                        ampl         <= to_ampl(fifo_dout[7:0]);
                        sample_valid <= 1'b1;
                        emitted      <= 1'b1;
                        pend0        <= 1'b0;
                        tick_cnt     <= '0;
                    end else begin
                        pend0 <= 1'b1;
                    end
                end

                PLAY: begin
                    if (tick) begin
                        if (pend0) begin
                            ampl         <= to_ampl(word_q[7:0]);
                            sample_valid <= 1'b1;
                            pend0        <= 1'b0;
                        end else if (byte_idx != 2'd3) begin
                            byte_idx     <= byte_nxt;
                            ampl         <= to_ampl(word_q[{byte_nxt, 3'b000} +: 8]);
                            sample_valid <= 1'b1;
                            // Emitting byte 3 of a non-final word: prefetch the
                            // next word now so its byte 0 lands on the next tick.
                            if ((byte_nxt == 2'd3) && (len_rem != LEN_W'(1))) begin
                                len_rem <= len_rem - LEN_W'(1);
                                state   <= FETCH;
                            end
                        end else begin
                            // Final word's byte 3 has had its full period.
                            len_rem <= len_rem - LEN_W'(1);
                            done    <= 1'b1;
                            state   <= FINISH;
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sample_playback_ctrl.md
SAMPLE_PLAYBACK_CTRL -- requirements
Module: sample_playback_ctrl

Interface
REQ-001 SHALL have parameter RATE_W, default 16, width of rate_div.
REQ-002 SHALL have parameter LEN_W, default 24, width of play_len (32-bit words per playback).
REQ-003 SHALL have port okClk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port mst_reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port trigger  input  1  asynchronous start request from the Arduino.
REQ-006 SHALL have port play_len  input  LEN_W  words to play; latched at start.
REQ-007 SHALL have port rate_div  input  RATE_W  okClk cycles per sample minus 1; latched at start.
REQ-008 SHALL have port fifo_dout  input  32  word from the DDR3-to-DAC FIFO, valid 1 cycle after fifo_rd_en.
REQ-009 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-010 SHALL have port fifo_rd_en  output  1  FIFO read strobe.
REQ-011 SHALL have port ampl  output  12  amplitude to the DAC controller.
REQ-012 SHALL have port sample_valid  output  1  one-cycle pulse when ampl updates.
REQ-013 SHALL have port busy, done, underrun  output  1 each  playing; end-of-playback pulse; sticky starvation flag.

Function
REQ-014 SHALL synchronise trigger through two flops; start = rising edge of the synchronised signal.
REQ-015 SHALL implement states IDLE, FETCH, LOAD, PLAY, FINISH.
REQ-016 IDLE: on start with play_len != 0 latch play_len/rate_div, clear underrun, go FETCH; start with play_len == 0 ignored.
REQ-017 FETCH: assert fifo_rd_en for exactly one cycle when fifo_empty == 0, then LOAD; while empty, wait and set underrun if any sample was already emitted this playback.
REQ-018 LOAD: capture fifo_dout into word register, byte index := 0, go PLAY; first sample of a word emitted in the LOAD-to-PLAY cycle.
REQ-019 PLAY: emit byte[7:0] first, then [15:8], [23:16], [31:24]; one sample per rate tick, tick period = max(rate_div,1)+1 cycles.
REQ-020 On each emit, ampl updates and sample_valid pulses in the same cycle; ampl holds between emits.
REQ-021 After byte 3, decrement remaining words; if zero go FINISH, else go FETCH at the next tick boundary.
REQ-022 FINISH: pulse done for one cycle, return to IDLE; ampl holds last sample.
REQ-023 Trigger edges while busy SHALL be ignored; busy = 1 in every state except IDLE.
REQ-024 Underrun SHALL NOT emit samples or repeat bytes; playback resumes with the next FIFO word, and underrun stays set until the next accepted start or reset.
REQ-025 Without PLAYBACK_SIGNED_EN, ampl = {4'b0, byte}.
REQ-026 fifo_rd_en SHALL never assert while fifo_empty == 1 or outside FETCH.

Reset
REQ-027 While mst_reset_n == 0 at a clock edge, state is IDLE and all outputs are 0 (ampl = 0, or 12'h800 with PLAYBACK_SIGNED_EN); counters and synchroniser clear.
REQ-028 Reset mid-playback SHALL abort immediately; done does not pulse and no FIFO read is issued.

Configuration
REQ-029 With PLAYBACK_SIGNED_EN defined, bytes SHALL be two's complement and ampl = {~byte[7], byte[6:0], 4'b0}; without it, REQ-025 applies.

Verification
REQ-030 play_len=1, rate_div=3, FIFO word 32'h44332211, trigger pulse -> ampl 11,22,33,44 with sample_valid 4 cycles apart; one fifo_rd_en; done pulse; busy=0.
REQ-031 play_len=2, rate_div=0, two words ready -> 8 samples 2 cycles apart, exactly 2 fifo_rd_en, underrun=0.
REQ-032 play_len=2, second word arrives 20 cycles late -> underrun=1, no sample_valid during gap, remaining 4 bytes emitted, done pulse.
REQ-033 Trigger re-pulsed mid-playback, and trigger with play_len=0 -> no restart, no state change.
REQ-034 mst_reset_n low during PLAY -> next cycle IDLE, all outputs 0, no done.
REQ-035 PLAYBACK_SIGNED_EN defined, byte 8'h80 then 8'h7F -> ampl 12'h000 then 12'hFF0; reset value 12'h800.
